// File: rtl/dds_sweep_ctrl.sv
// Purpose: steps the DDS phase-increment word through a programmed sweep and drives the ZOH divider.
// Latency: start -> first cfg_load is 2 cycles; each further step adds dwell ticks + 2 cycles.
// Backpressure: none; start is ignored unless idle, ticks outside DWELL are dropped, abort wins over all.
module dds_sweep_ctrl #(
    parameter int PIR_W = 32,
    parameter int DIV_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PIR_W-1:0] pir_start,
    input  logic [PIR_W-1:0] pir_step,
    input  logic [CNT_W-1:0] step_count,
    input  logic [CNT_W-1:0] dwell_ticks,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             tick,
    output logic [PIR_W-1:0] pir,
    output logic [DIV_W-1:0] divider,
    output logic             cfg_load,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DWELL,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;

    // Sweep parameters captured at start so the control registers can change mid-sweep.
    logic [PIR_W-1:0] acc;
    logic [PIR_W-1:0] inc_lat;
    logic [CNT_W-1:0] steps_lat;
    logic [CNT_W-1:0] dwell_lat;
    logic [DIV_W-1:0] div_lat;
    logic [CNT_W-1:0] dwell_cnt;

    logic [CNT_W-1:0] dwell_last;
    logic             dwell_end;
    logic             last_step;
    logic             abort_hit;

    // A dwell of zero ticks behaves as a dwell of one tick.
    assign dwell_last = (dwell_lat == '0) ? '0 : dwell_lat - CNT_ONE;
    assign dwell_end  = tick && (dwell_cnt == dwell_last);
    assign last_step  = (step_idx == steps_lat - CNT_ONE);
    assign abort_hit  = abort && (state != S_IDLE);

    assign busy = (state == S_LOAD) || (state == S_DWELL) || (state == S_STEP);
    assign done = (state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (step_count == '0) ? S_DONE : S_LOAD;
            S_LOAD:  state_nxt = S_DWELL;
            S_DWELL: if (dwell_end) state_nxt = last_step ? S_DONE : S_STEP;
            S_STEP:  state_nxt = S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: parameter capture, accumulator, outputs and dwell counter. On abort
    // everything holds, so pir/divider keep the last value the DDS was given.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= '0;
            inc_lat   <= '0;
            steps_lat <= '0;
            dwell_lat <= '0;
            div_lat   <= '0;
            dwell_cnt <= '0;
            step_idx  <= '0;
            pir       <= '0;
            divider   <= '0;
            cfg_load  <= 1'b0;
        end else begin
            cfg_load <= 1'b0;
            if (!abort_hit) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            acc       <= pir_start;
                            inc_lat   <= pir_step;
                            steps_lat <= step_count;
                            dwell_lat <= dwell_ticks;
                            div_lat   <= div_cfg;
                            step_idx  <= '0;
                        end
                    end
                    S_LOAD: begin
                        pir       <= acc;
                        divider   <= div_lat;
                        cfg_load  <= 1'b1;
                        dwell_cnt <= '0;
                    end
                    S_DWELL: begin
                        if (tick) begin
                            dwell_cnt <= dwell_cnt + CNT_ONE;
                        end
                    end
                    S_STEP: begin
                        acc      <= acc + inc_lat;
                        step_idx <= step_idx + CNT_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
